sent_tx_crc_engine: RTL and testbench
=====================================

Name: sent_tx_crc_engine

Overview:
- Parametrised SENT transmit CRC generator. Successor to the fixed-length 4/6-bit CRC generator.
- Computes the SAE-style CRC4 (fast-channel and short serial messages) or CRC6 (enhanced serial message) over a variable number of data nibbles.
- Processes a configurable number of bits per clock. Uses valid/ready handshakes on both request and result.
- Carries a channel tag through, so one engine can be shared by several SENT TX channels in the transmit control path.

Parameters:
- MAX_NIBBLES, 6, maximum data nibbles per request (legal 1..8).
- BPC, 1, bits processed per clock (legal 1 or 2).
- TAG_W, 2, width of the pass-through channel tag.
- SEED4, 4'b0101, CRC4 initial remainder.
- SEED6, 6'b010101, CRC6 initial remainder.

Ports:
- clk_tx  in  1  clock
- reset_n_tx  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  engine idle and accepting
- mode_i  in  2  00=CRC4, 01=CRC6, 10/11 reserved
- len_i  in  4  number of data nibbles
- data_i  in  4*MAX_NIBBLES  data, right-aligned; first-sent nibble at bits [4*len_i-1 -: 4]
- tag_i  in  TAG_W  channel id
- abort_i  in  1  synchronous abort
- crc_valid_o  out  1  result valid
- crc_ready_i  in  1  result accepted
- crc_o  out  6  CRC, CRC4 in [3:0] with [5:4]=0
- crc_mode_o  out  2  echo of the accepted mode
- tag_o  out  TAG_W  echo of the accepted tag
- err_o  out  1  request was illegal; qualified by crc_valid_o
- inj_i  in  1  present only with SENT_CRC_ERR_INJ_EN

Behaviour:
- Clock and reset: clk_tx; reset reset_n_tx, asynchronous, active-low.
- Reset values: state IDLE, req_ready_o=1, crc_valid_o=0, crc_o=0, crc_mode_o=0, tag_o=0, err_o=0, all internal registers 0.
- CRC definition: W=4 with polynomial x^4+x^3+x^2+1 (11101), or W=6 with polynomial x^6+x^4+x^3+1 (1011001).
  - Result = remainder of {seed, data bits MSB-first, W zero bits} divided by the polynomial.
  - Equivalent LFSR step per bit b: fb=r[W-1]; r={r[W-2:0],b} ^ (fb ? poly[W-1:0] : 0).
- States: IDLE, RUN, DONE.
- IDLE: acceptance = req_valid_i & req_ready_o at a rising edge.
  - On acceptance: latch mode, tag and data; r<=seed; cnt<=N-1, where N=(4*len_i+W)/BPC.
  - Legal request -> RUN.
  - Illegal request -> DONE with err_o=1 and crc_o=0.
- Illegal request = any of: len_i=0; len_i>MAX_NIBBLES; mode 10 or 11; CRC6 with len_i!=6.
- RUN: each edge consumes BPC bits (data first, then the W zero bits) and decrements cnt.
  - On the edge where cnt==0: load crc_o from the final remainder, set crc_valid_o=1, go to DONE.
  - crc_valid_o rises exactly N edges after the acceptance edge. Example: CRC4, len 6, BPC=1 -> 28.
- DONE: crc_o, crc_mode_o, tag_o and err_o are held stable while crc_valid_o=1.
  - On crc_valid_o & crc_ready_i -> IDLE. crc_valid_o=0 and req_ready_o=1 on the following cycle.
  - crc_o retains its value until the next result.
- req_ready_o=1 only in IDLE. There is no back-to-back overlap; requests presented outside IDLE are not sampled.
- abort_i in RUN or DONE: next edge -> IDLE, crc_valid_o=0, no result emitted. abort_i in IDLE has no effect.
- Simultaneous events: abort_i wins over crc_ready_i.
- Reset mid-operation: immediate return to the reset values; the partial result is discarded.

Optional Feature:
- Macro: SENT_CRC_ERR_INJ_EN.
- When defined:
  - Port inj_i exists and is sampled at acceptance.
  - If set, crc_o[0] is inverted in the result. This lets benches and system tests force a receiver CRC error.
  - err_o is unaffected.
- When undefined: inj_i is absent and crc_o is always the true CRC.

Test Plan:
- Reset, then CRC4, len=6, data=0x000000, BPC=1 -> crc_valid_o rises 28 edges after acceptance, crc_o=0x05, err_o=0.
- CRC4, len=6, data=0x000001 -> crc_o=0x08. Then CRC4, len=3, data=0x000 -> crc_o=0x09 after 16 edges.
- CRC6, len=6, data=0x000000 -> crc_o=0x26 after 30 edges; with BPC=2, the same value after 15 edges. crc_mode_o=01 and tag_o equal to tag_i.
- Illegal requests (mode=11; CRC6 with len=4; len=0) -> crc_valid_o one edge after acceptance, err_o=1, crc_o=0.
- Result held with crc_ready_i=0 for 5 cycles -> outputs stable and req_ready_o=0. Assert abort_i mid-RUN -> IDLE next edge, no crc_valid_o. Assert reset mid-RUN -> all outputs at reset values.
- With SENT_CRC_ERR_INJ_EN, inj_i=1, CRC4, len=6, data=0 -> crc_o=0x04. With the macro off, the same request -> crc_o=0x05.

Source files
------------

// File: rtl/sent_tx_crc_engine.sv
// sent_tx_crc_engine: shared SENT TX CRC4/CRC6 generator, BPC bits per clock, valid/ready on request and result.
// Define SENT_CRC_ERR_INJ_EN to add inj_i, which inverts crc_o[0] of the result it was accepted with.
module sent_tx_crc_engine #(
    parameter int         MAX_NIBBLES = 6,
    parameter int         BPC         = 1,
    parameter int         TAG_W       = 2,
    parameter logic [3:0] SEED4       = 4'b0101,
    parameter logic [5:0] SEED6       = 6'b010101
) (
    input  logic                     clk_tx,
    input  logic                     reset_n_tx,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [1:0]               mode_i,
    input  logic [3:0]               len_i,
    input  logic [4*MAX_NIBBLES-1:0] data_i,
    input  logic [TAG_W-1:0]         tag_i,
    input  logic                     abort_i,
`ifdef SENT_CRC_ERR_INJ_EN
    input  logic                     inj_i,
`endif
    output logic                     crc_valid_o,
    input  logic                     crc_ready_i,
    output logic [5:0]               crc_o,
    output logic [1:0]               crc_mode_o,
    output logic [TAG_W-1:0]         tag_o,
    output logic                     err_o
);
    localparam int SW = 4 * MAX_NIBBLES + 6;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    logic [5:0]      r_q, r_d, crc_q, cnt_q, cnt_ld, shamt;
    logic [SW-1:0]   sh_q, sh_d;
    logic [1:0]      mode_q;
    logic [TAG_W-1:0] tag_q;
    logic            err_q, illegal;
`ifdef SENT_CRC_ERR_INJ_EN
    logic            inj_q;
`endif

    // Data is left-aligned into the shifter so the first-sent nibble leaves first and the zero tail supplies the W flush bits.
    always_comb begin
        illegal = len_i == 4'd0 || int'(len_i) > MAX_NIBBLES || mode_i[1] || (mode_i == 2'b01 && len_i != 4'd6);
        shamt   = illegal ? 6'd0 : 6'(4 * (MAX_NIBBLES - int'(len_i)));
        cnt_ld  = 6'((4 * int'(len_i) + (mode_i[0] ? 6 : 4)) / BPC - 1);
        r_d     = r_q;
        for (int i = 0; i < BPC; i++)
            r_d = mode_q[0] ? {r_d[4:0], sh_q[SW-1-i]} ^ (r_d[5] ? 6'h19 : 6'h00)
                            : {2'b00, r_d[2:0], sh_q[SW-1-i]} ^ (r_d[3] ? 6'h0d : 6'h00);
        sh_d    = sh_q << BPC;
    end

    always_ff @(posedge clk_tx or negedge reset_n_tx) begin
        if (!reset_n_tx) begin
            state_q <= IDLE;
            r_q     <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            tag_q   <= '0;
            crc_q   <= '0;
            err_q   <= 1'b0;
`ifdef SENT_CRC_ERR_INJ_EN
            inj_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (req_valid_i) begin
                    state_q <= illegal ? DONE : RUN;
                    r_q     <= mode_i[0] ? SEED6 : {2'b00, SEED4};
                    sh_q    <= {data_i, 6'b0} << shamt;
                    cnt_q   <= cnt_ld;
                    mode_q  <= mode_i;
                    tag_q   <= tag_i;
                    err_q   <= illegal;
                    if (illegal) crc_q <= '0;
`ifdef SENT_CRC_ERR_INJ_EN
                    inj_q   <= inj_i;
`endif
                end
                RUN: if (abort_i) state_q <= IDLE;
                else begin
                    r_q   <= r_d;
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q - 6'd1;
                    if (cnt_q == 6'd0) begin
                        state_q <= DONE;
`ifdef SENT_CRC_ERR_INJ_EN
                        crc_q   <= r_d ^ {5'b0, inj_q};
`else
                        crc_q   <= r_d;
`endif
                    end
                end
                DONE: if (abort_i || crc_ready_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o = state_q == IDLE;
    assign crc_valid_o = state_q == DONE;
    assign crc_o       = crc_q;
    assign crc_mode_o  = mode_q;
    assign tag_o       = tag_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_sent_tx_crc_engine.sv
// tb_sent_tx_crc_engine: BPC=1 and BPC=2 engines checked against a long-division CRC model.
module tb_sent_tx_crc_engine;
    logic        clk_tx = 1'b0, reset_n_tx = 1'b0, req_valid_i = 1'b0, abort_i = 1'b0, crc_ready_i = 1'b0;
    logic [1:0]  mode_i = '0, tag_i = '0;
    logic [3:0]  len_i = '0;
    logic [23:0] data_i = '0;
`ifdef SENT_CRC_ERR_INJ_EN
    logic        inj_i = 1'b0;
`endif
    logic        rdy1, vld1, err1, rdy2, vld2, err2;
    logic [5:0]  crc1, crc2;
    logic [1:0]  cm1, cm2, tg1, tg2;
    int          checks = 0, errors = 0;

    always #5 clk_tx = ~clk_tx;

    sent_tx_crc_engine #(.BPC(1)) dut1 (
        .clk_tx(clk_tx), .reset_n_tx(reset_n_tx), .req_valid_i(req_valid_i), .req_ready_o(rdy1),
        .mode_i(mode_i), .len_i(len_i), .data_i(data_i), .tag_i(tag_i), .abort_i(abort_i),
`ifdef SENT_CRC_ERR_INJ_EN
        .inj_i(inj_i),
`endif
        .crc_valid_o(vld1), .crc_ready_i(crc_ready_i), .crc_o(crc1), .crc_mode_o(cm1),
        .tag_o(tg1), .err_o(err1));

    sent_tx_crc_engine #(.BPC(2)) dut2 (
        .clk_tx(clk_tx), .reset_n_tx(reset_n_tx), .req_valid_i(req_valid_i), .req_ready_o(rdy2),
        .mode_i(mode_i), .len_i(len_i), .data_i(data_i), .tag_i(tag_i), .abort_i(abort_i),
`ifdef SENT_CRC_ERR_INJ_EN
        .inj_i(inj_i),
`endif
        .crc_valid_o(vld2), .crc_ready_i(crc_ready_i), .crc_o(crc2), .crc_mode_o(cm2),
        .tag_o(tg2), .err_o(err2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Remainder of {seed, data MSB-first, W zeros} by polynomial long division.
    function automatic logic [5:0] model_crc(input logic m6, input int l, input logic [23:0] d);
        bit         b[64];
        int         n = 0;
        int         w = m6 ? 6 : 4;
        logic [6:0] p = m6 ? 7'h59 : 7'h1d;
        logic [5:0] s = m6 ? 6'h15 : 6'h05;
        logic [5:0] rem = '0;
        for (int i = w - 1; i >= 0; i--) begin b[n] = s[i]; n++; end
        for (int i = 4 * l - 1; i >= 0; i--) begin b[n] = d[i]; n++; end
        for (int i = 0; i < w; i++) begin b[n] = 1'b0; n++; end
        for (int i = 0; i < n - w; i++)
            if (b[i]) for (int j = 0; j <= w; j++) b[i+j] ^= p[w-j];
        for (int i = n - w; i < n; i++) rem = {rem[4:0], b[i]};
        return rem;
    endfunction

    // Entered and left at #1 after a rising edge.
    task automatic run_req(input logic [1:0] m, input logic [3:0] l, input logic [23:0] d,
                           input logic [1:0] t, input logic inj, input int exp_crc, input int hold);
        logic       ill;
        int         n, lat1, lat2;
        logic [5:0] e;
        ill = l == 0 || l > 6 || m[1] || (m == 2'b01 && l != 6);
        n   = 4 * int'(l) + (m[0] ? 6 : 4);
        e   = ill ? 6'd0 : (exp_crc >= 0 ? 6'(exp_crc) : model_crc(m[0], int'(l), d));
`ifdef SENT_CRC_ERR_INJ_EN
        if (!ill) e[0] = e[0] ^ inj;
        inj_i = inj;
`else
        if (inj) e = e;
`endif
        chk("ready_before", {30'b0, rdy1, rdy2}, 32'd3);
        req_valid_i = 1'b1; mode_i = m; len_i = l; data_i = d; tag_i = t;
        @(posedge clk_tx); #1;
        req_valid_i = 1'b0;
        lat1 = -1; lat2 = -1;
        for (int k = 0; k < 80; k++) begin
            if (vld1 && lat1 < 0) lat1 = k;
            if (vld2 && lat2 < 0) lat2 = k;
            if (lat1 >= 0 && lat2 >= 0) break;
            @(posedge clk_tx); #1;
        end
        chk("lat_bpc1", lat1, ill ? 0 : n);
        chk("lat_bpc2", lat2, ill ? 0 : n / 2);
        chk("crc_bpc1", {26'b0, crc1}, {26'b0, e});
        chk("crc_bpc2", {26'b0, crc2}, {26'b0, e});
        chk("flags_bpc1", {rdy1, vld1, cm1, tg1, err1}, {1'b0, 1'b1, m, t, ill});
        chk("flags_bpc2", {rdy2, vld2, cm2, tg2, err2}, {1'b0, 1'b1, m, t, ill});
        repeat (hold) begin @(posedge clk_tx); #1; end
        if (hold > 0) chk("held", {rdy1, vld1, crc1, cm1, tg1, err1, rdy2, vld2, crc2, cm2, tg2, err2},
                              {2'b01, e, m, t, ill, 2'b01, e, m, t, ill});
        crc_ready_i = 1'b1;
        @(posedge clk_tx); #1;
        crc_ready_i = 1'b0;
        chk("after_ready", {rdy1, vld1, crc1, rdy2, vld2, crc2}, {2'b10, e, 2'b10, e});
    endtask

    task automatic start_req(input logic [1:0] m, input logic [3:0] l);
        req_valid_i = 1'b1; mode_i = m; len_i = l; data_i = 24'($urandom); tag_i = 2'($urandom);
        @(posedge clk_tx); #1;
        req_valid_i = 1'b0;
    endtask

    initial begin
        int seen;
        logic [1:0] m;
        logic [3:0] l;
        int r;
        repeat (3) @(posedge clk_tx);
        #1;
        chk("reset_vals", {rdy1, vld1, crc1, cm1, tg1, err1, rdy2, vld2, crc2, cm2, tg2, err2}, {13'h1000, 13'h1000});
        @(negedge clk_tx) reset_n_tx = 1'b1;
        @(posedge clk_tx); #1;

        run_req(2'b00, 4'd6, 24'h000000, 2'd1, 1'b0, 'h05, 0);
        run_req(2'b00, 4'd6, 24'h000001, 2'd2, 1'b0, 'h08, 0);
        run_req(2'b00, 4'd3, 24'h000000, 2'd3, 1'b0, 'h09, 0);
        run_req(2'b01, 4'd6, 24'h000000, 2'd2, 1'b0, 'h26, 5);
        run_req(2'b00, 4'd6, 24'h000000, 2'd0, 1'b1, 'h05, 0);
        run_req(2'b11, 4'd6, 24'h123456, 2'd1, 1'b0, -1, 2);
        run_req(2'b01, 4'd4, 24'h001234, 2'd3, 1'b0, -1, 0);
        run_req(2'b00, 4'd0, 24'hffffff, 2'd2, 1'b0, -1, 0);
        run_req(2'b00, 4'd7, 24'hffffff, 2'd0, 1'b0, -1, 0);
        run_req(2'b00, 4'd1, 24'hfffffa, 2'd1, 1'b0, -1, 1);

        start_req(2'b00, 4'd6);
        repeat (5) @(posedge clk_tx);
        #1 abort_i = 1'b1;
        @(posedge clk_tx); #1;
        abort_i = 1'b0;
        chk("abort_run", {rdy1, vld1, rdy2, vld2}, 4'b1010);
        seen = 0;
        repeat (40) begin @(posedge clk_tx); #1; if (vld1 || vld2) seen++; end
        chk("abort_no_result", seen, 0);

        start_req(2'b00, 4'd1);
        repeat (10) @(posedge clk_tx);
        #1 chk("pre_abort_done", {vld1, vld2}, 2'b11);
        abort_i = 1'b1; crc_ready_i = 1'b1;
        @(posedge clk_tx); #1;
        abort_i = 1'b0; crc_ready_i = 1'b0;
        chk("abort_done", {rdy1, vld1, rdy2, vld2}, 4'b1010);

        start_req(2'b01, 4'd6);
        repeat (7) @(posedge clk_tx);
        #2 reset_n_tx = 1'b0;
        #1 chk("reset_mid_run", {rdy1, vld1, crc1, cm1, tg1, err1, rdy2, vld2, crc2, cm2, tg2, err2}, {13'h1000, 13'h1000});
        @(negedge clk_tx) reset_n_tx = 1'b1;
        @(posedge clk_tx); #1;

        for (int i = 0; i < 30; i++) begin
            r = int'($urandom_range(0, 5));
            m = r < 3 ? 2'b00 : r < 5 ? 2'b01 : 2'($urandom_range(2, 3));
            l = (m == 2'b01 && $urandom_range(0, 3) != 0) ? 4'd6 : 4'($urandom_range(0, 9));
            run_req(m, l, 24'($urandom), 2'($urandom), 1'($urandom), -1, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
